pkt_fetch: RTL and testbench

Downstream consumer of the packet RAM. On a start command, it walks a packet stored in the RAM by issuing word-aligned byte addresses. It absorbs the RAM's fixed one-cycle registered read latency. It presents the packet words on a valid/ready stream to the parser stage, with last-word marking and a small credit-controlled FIFO so that backpressure never drops a word.

---
 rtl/pkt_fetch.sv | 147 ++++++++++++++
 tb/tb_pkt_fetch.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_fetch.sv
// Packet fetch engine: walks a packet in a registered-read RAM and streams its
// words out through a credit-controlled FIFO with last-word marking.
module pkt_fetch #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [LEN_WIDTH-1:0]  len_i,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  input  logic [DATA_WIDTH-1:0] ram_data_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  output logic                  last_o,
  input  logic                  ready_i,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  rem_q;
  logic                  infl_q;
  logic                  infl_last_q;
  logic                  busy_q;
  logic                  done_q;
  logic [PW-1:0]         wptr_q;
  logic [PW-1:0]         rptr_q;
  logic [CW-1:0]         cnt_q;
  logic [CW-1:0]         cnt_d;
  logic [DATA_WIDTH-1:0] mem_q  [FIFO_DEPTH];
  logic                  lastf_q [FIFO_DEPTH];

  logic                  push;
  logic                  pop;
  logic                  issue;
  logic                  head_last;
  logic [CW:0]           used;
  logic                  unused_base;

  assign unused_base = ^base_addr_i[1:0];

  assign push      = infl_q;
  assign pop       = (cnt_q != '0) && ready_i;
  assign head_last = lastf_q[rptr_q];

  // The read still in flight already owns a FIFO slot, so it counts as used.
  assign used  = {1'b0, cnt_q} + {{CW{1'b0}}, infl_q};
  assign issue = (state_q == S_FETCH) && (rem_q != '0) &&
                 (used < (CW+1)'(FIFO_DEPTH));

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      cnt_q       <= '0;
    end else begin
      infl_q      <= issue;
      infl_last_q <= issue && (rem_q == LEN_WIDTH'(1));
      if (issue) begin
        addr_q <= addr_q + ADDR_WIDTH'(4);
        rem_q  <= rem_q - LEN_WIDTH'(1);
      end
      if (push) wptr_q <= wptr_q + PW'(1);
      if (pop)  rptr_q <= rptr_q + PW'(1);
      cnt_q <= cnt_d;

      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            addr_q  <= {base_addr_i[ADDR_WIDTH-1:2], 2'b00};
            rem_q   <= len_i;
            busy_q  <= 1'b1;
            state_q <= (len_i != '0) ? S_FETCH : S_DONE;
          end
        end
        S_FETCH: begin
          if (issue && (rem_q == LEN_WIDTH'(1))) state_q <= S_DRAIN;
        end
        S_DRAIN: begin
          // The last word is the newest entry, so its acceptance empties the FIFO.
          if (pop && head_last && !infl_q) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          // An empty packet arrives here without the pulse armed; arm it first.
          if (done_q) begin
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            done_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Capture stage: the RAM word for last cycle's issue lands in the FIFO tail.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q]   <= ram_data_i;
      lastf_q[wptr_q] <= infl_last_q;
    end
  end

  assign ram_addr_o = addr_q;
  assign valid_o    = (cnt_q != '0);
  assign data_o     = valid_o ? mem_q[rptr_q] : '0;
  assign last_o     = valid_o ? head_last : 1'b0;
  assign busy_o     = busy_q;
  assign done_o     = done_q;

endmodule

// File: tb/tb_pkt_fetch.sv
// Scoreboard bench for pkt_fetch: a 64-word registered-read RAM model feeds the
// DUT; expected words are queued at start and popped by an independent monitor.
module tb_pkt_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [31:0] base_addr_i;
  logic [7:0]  len_i;
  logic [31:0] ram_addr_o;
  logic [31:0] ram_data_i;
  logic [31:0] data_o;
  logic        valid_o;
  logic        last_o;
  logic        ready_i;
  logic        busy_o;
  logic        done_o;

  typedef struct {
    logic [31:0] d;
    logic        l;
  } exp_t;

  exp_t        q[$];
  logic [31:0] mem [64];
  int          n_checks = 0;
  int          n_err = 0;

  pkt_fetch #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .LEN_WIDTH(8), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .base_addr_i(base_addr_i),
    .len_i(len_i), .ram_addr_o(ram_addr_o), .ram_data_i(ram_data_i),
    .data_o(data_o), .valid_o(valid_o), .last_o(last_o), .ready_i(ready_i),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memval(int i);
    return {16'hC0DE, 8'(i), 8'(~i)};
  endfunction

  // Registered-read RAM: data for the address seen at an edge appears after it.
  always @(posedge clk) ram_data_i <= mem[ram_addr_o[7:2]];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push_pkt(logic [31:0] base, int len);
    exp_t e;
    for (int i = 0; i < len; i++) begin
      e.d = memval(((base >> 2) + i) & 63);
      e.l = (i == len - 1);
      q.push_back(e);
    end
  endtask

  task automatic start_pkt(logic [31:0] base, logic [7:0] len);
    @(posedge clk);
    #1;
    base_addr_i = base;
    len_i       = len;
    start_i     = 1'b1;
    push_pkt(base, int'(len));
    @(posedge clk);
    #1;
    start_i = 1'b0;
  endtask

  task automatic wait_done(int maxc, bit rnd);
    bit seen = 0;
    for (int i = 0; i < maxc && !seen; i++) begin
      @(posedge clk);
      #1;
      if (rnd) ready_i = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (done_o) seen = 1;
    end
    if (!seen) begin
      n_checks++;
      n_err++;
      $display("FAIL done_timeout: got no done_o within %0d cycles", maxc);
    end
  endtask

  // Monitor: pops and compares every accepted word, checks hold under backpressure.
  initial begin
    logic [31:0] hold_d;
    logic        hold_l;
    logic        hold_v;
    exp_t        e;
    hold_v = 1'b0;
    hold_d = '0;
    hold_l = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_v = 1'b0;
      end else begin
        if (hold_v && valid_o) begin
          chk("stall_data", data_o, hold_d);
          chk("stall_last", 32'(last_o), 32'(hold_l));
        end
        if (valid_o && ready_i) begin
          if (q.size() == 0) begin
            chk("extra_word", data_o, 32'hXXXX_XXXX);
          end else begin
            e = q.pop_front();
            chk("word_data", data_o, e.d);
            chk("word_last", 32'(last_o), 32'(e.l));
          end
        end
        hold_v = valid_o && !ready_i;
        hold_d = data_o;
        hold_l = last_o;
      end
    end
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = memval(i);
    rst = 1'b1;
    start_i = 1'b0;
    base_addr_i = '0;
    len_i = '0;
    ready_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_addr", ram_addr_o, 32'h0);
    chk("rst_valid", 32'(valid_o), 32'h0);
    chk("rst_data", data_o, 32'h0);
    chk("rst_last", 32'(last_o), 32'h0);
    chk("rst_busy", 32'(busy_o), 32'h0);
    chk("rst_done", 32'(done_o), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Basic packet: base 0x10, len 3, ready held high.
    start_pkt(32'h10, 8'd3);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c <= 3) chk("t1_addr", ram_addr_o, 32'h10 + 32'(4 * (c - 1)));
      chk("t1_valid", 32'(valid_o), 32'((c >= 3) && (c <= 5)));
      chk("t1_busy", 32'(busy_o), 32'(c <= 6));
      chk("t1_done", 32'(done_o), 32'(c == 6));
    end
    chk("t1_q_empty", 32'(q.size()), 32'h0);

    // Empty packet.
    start_pkt(32'h40, 8'd0);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      chk("t2_valid", 32'(valid_o), 32'h0);
      chk("t2_busy", 32'(busy_o), 32'(c <= 2));
      chk("t2_done", 32'(done_o), 32'(c == 2));
    end

    // Backpressure: four reads fill the FIFO, then the address freezes.
    ready_i = 1'b0;
    start_pkt(32'h20, 8'd8);
    repeat (9) @(negedge clk);
    chk("t3_addr_frozen", ram_addr_o, 32'h30);
    chk("t3_valid", 32'(valid_o), 32'h1);
    @(negedge clk);
    chk("t3_addr_hold", ram_addr_o, 32'h30);
    @(posedge clk);
    #1 ready_i = 1'b1;
    wait_done(60, 1'b0);
    chk("t3_q_empty", 32'(q.size()), 32'h0);

    // Random backpressure with word-index wrap 60..63, 0..15.
    start_pkt(32'hF0, 8'd20);
    wait_done(600, 1'b1);
    ready_i = 1'b1;
    chk("t4_q_empty", 32'(q.size()), 32'h0);

    // Reset mid-packet, then a fresh short packet.
    start_pkt(32'h0, 8'd10);
    for (int i = 0; i < 60 && q.size() > 6; i++) @(negedge clk);
    chk("t5_four_words", 32'(q.size() <= 6), 32'h1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    q.delete();
    @(negedge clk);
    chk("t5_addr", ram_addr_o, 32'h0);
    chk("t5_valid", 32'(valid_o), 32'h0);
    chk("t5_data", data_o, 32'h0);
    chk("t5_busy", 32'(busy_o), 32'h0);
    chk("t5_done", 32'(done_o), 32'h0);
    start_pkt(32'h0, 8'd2);
    wait_done(30, 1'b0);
    chk("t5_q_empty", 32'(q.size()), 32'h0);

    // A second start while busy is ignored.
    start_pkt(32'h40, 8'd4);
    @(posedge clk);
    #1;
    base_addr_i = 32'h80;
    len_i = 8'd5;
    start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    wait_done(30, 1'b0);
    chk("t6_q_empty", 32'(q.size()), 32'h0);
    repeat (3) begin
      @(negedge clk);
      chk("t6_idle_valid", 32'(valid_o), 32'h0);
      chk("t6_idle_busy", 32'(busy_o), 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
